aes_result_collector: RTL and testbench
=======================================

Name: aes_result_collector

Overview:
- Consumer end of the aes_engine output interface: samples the pipelined result stream (out/out_type) and buffers valid results in a first-word-fall-through (FWFT) FIFO.
- Presents buffered results downstream on a valid/ready handshake, each tagged with a sequence number.
- Back-pressures the engine by driving its halt input whenever FIFO occupancy reaches a threshold, so no result is ever lost.
- Keeps per-type result counters and a malformed-type counter for the host.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, 2..64.
- HALT_THRESH, DEPTH, occupancy at or above which halt is asserted; legal range 1..DEPTH.
- CNT_W, 16, width of the enc/dec/err counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- res_data  in  128  engine result word (engine out)
- res_type  in  2  engine result type, job_t (engine out_type)
- halt  out  1  freeze request to the engine (engine halt)
- flush  in  1  synchronous clear of FIFO and sequence number; counters are kept
- m_valid  out  1  head entry available
- m_ready  in  1  downstream accepts the head entry
- m_data  out  128  head result word
- m_type  out  2  head job_t; only ENCRYPT or DECRYPT
- m_seq  out  8  head sequence tag
- occupancy  out  $clog2(DEPTH)+1  current entry count
- enc_cnt  out  CNT_W  accepted ENCRYPT results, saturating
- dec_cnt  out  CNT_W  accepted DECRYPT results, saturating
- err_cnt  out  CNT_W  dropped malformed-type results, saturating

Behaviour:
- Reset (async assert, sync release): FIFO empty, occupancy=0, halt=0, m_valid=0, m_data=0, m_type=INVALID, m_seq=0, all counters 0, sequence counter 0.
- Capture condition: push = !halt && res_type ∈ {ENCRYPT, DECRYPT}. halt is the registered output value. The engine holds out/out_type while halted, so a result present during halt is captured on the first edge after halt drops. It is never captured twice.
- INVALID results are ignored silently.
- Any other encoding (not ENCRYPT, DECRYPT or INVALID) with !halt: dropped, err_cnt+1, no FIFO write.
- On push: write {res_data, res_type, seq}, then seq <= seq+1 (8-bit, wraps 255->0). The matching enc_cnt or dec_cnt increments and saturates at all-ones.
- FWFT output: m_valid = (occupancy != 0). m_data, m_type and m_seq show the head entry combinationally from storage. m_data/m_type/m_seq are 0/INVALID/0 when empty.
- pop = m_valid && m_ready.
- occupancy_next = occupancy + push - pop. Push and pop in the same cycle leave occupancy unchanged.
- Push and pop on an empty FIFO are legal: the entry appears on m_* the next cycle, and occupancy goes 0->1->... No bypass; minimum latency is 1 cycle.
- halt register: halt <= (occupancy_next >= HALT_THRESH). Because push requires !halt, occupancy never exceeds HALT_THRESH and the FIFO never overflows.
- Pop while full: halt deasserts the next cycle. A push is accepted on the following edge.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from occupancy, not from pointer compare.
- flush: has priority over push and pop that cycle. Sets occupancy=0, pointers=0, seq=0, halt=0 next cycle. Counters are untouched.
- Downstream must hold m_ready stable only per cycle. There is no requirement on m_valid de-assertion beyond the FIFO state.
- Reset mid-operation: all state clears immediately (async), and halt drops at once, releasing the engine.

Test Plan:
- Single encrypt: res_type=ENCRYPT, res_data=69c4e0d86a7b0430d8cdb78070b4c55a for one cycle, m_ready=1 -> next cycle m_valid=1, m_data equal to that word, m_type=ENCRYPT, m_seq=0. The cycle after, m_valid=0 and enc_cnt=1.
- Mixed stream: encrypt result 69c4…c55a then decrypt result 00112233445566778899aabbccddeeff, with m_ready=0 -> occupancy=2, head seq=0 (ENCRYPT). Raise m_ready -> both pop in order with seq 0,1. enc_cnt=1, dec_cnt=1.
- Back-pressure: DEPTH=8, m_ready=0, 10 consecutive valid results -> halt=1 from the cycle after the 8th push, occupancy stays 8. Assert m_ready for 1 cycle -> halt=0 next cycle, the 9th result is captured exactly once, occupancy=8, no loss or duplicate in seq order 0..9.
- Malformed type: res_type=2'b11 for 3 cycles -> err_cnt=3, occupancy=0, m_valid=0. INVALID for 5 cycles -> no counter change.
- Sequence wrap: push 257 results with m_ready=1 -> m_seq runs 0..255 then 0. enc_cnt=257.
- Flush/reset mid-operation: occupancy=5 with halt low, then assert flush together with a valid push -> next cycle occupancy=0, m_valid=0, seq=0. Separately, assert rst while halt=1 -> halt=0 without waiting for a clock edge.

Source files
------------

// File: rtl/aes_result_collector.sv
// Collects the aes_engine result stream into a first-word-fall-through FIFO,
// tags each result with a sequence number and halts the engine near full.
module aes_result_collector #(
  parameter int DEPTH       = 8,
  parameter int HALT_THRESH = DEPTH,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [127:0]             res_data,
  input  logic [1:0]               res_type,
  output logic                     halt,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [127:0]             m_data,
  output logic [1:0]               m_type,
  output logic [7:0]               m_seq,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         enc_cnt,
  output logic [CNT_W-1:0]         dec_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] T_INVALID = 2'b00;
  localparam logic [1:0] T_ENCRYPT = 2'b01;
  localparam logic [1:0] T_DECRYPT = 2'b10;
  localparam logic [AW:0] THRESH   = (AW+1)'(HALT_THRESH);

  logic [127:0]     data_mem [DEPTH];
  logic [1:0]       type_mem [DEPTH];
  logic [7:0]       seq_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      occ_reg, occ_next;
  logic [7:0]       seq_reg;
  logic             halt_reg, halt_next;
  logic [CNT_W-1:0] enc_cnt_reg, dec_cnt_reg, err_cnt_reg;

  logic is_enc, is_dec, is_bad, push, pop;

  always_comb begin
    is_enc    = (res_type == T_ENCRYPT);
    is_dec    = (res_type == T_DECRYPT);
    is_bad    = !is_enc && !is_dec && (res_type != T_INVALID);
    // The registered halt gates capture, so a held result is taken exactly once.
    push      = !halt_reg && !flush && (is_enc || is_dec);
    pop       = (occ_reg != '0) && m_ready && !flush;
    occ_next  = flush ? '0 : occ_reg + (AW+1)'(push) - (AW+1)'(pop);
    halt_next = !flush && (occ_next >= THRESH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      occ_reg     <= '0;
      seq_reg     <= '0;
      halt_reg    <= 1'b0;
      enc_cnt_reg <= '0;
      dec_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else begin
      occ_reg  <= occ_next;
      halt_reg <= halt_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        seq_reg    <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_reg + AW'(push);
        rd_ptr_reg <= rd_ptr_reg + AW'(pop);
        seq_reg    <= seq_reg + 8'(push);
      end
      if (push && is_enc && (enc_cnt_reg != '1)) enc_cnt_reg <= enc_cnt_reg + 1'b1;
      if (push && is_dec && (dec_cnt_reg != '1)) dec_cnt_reg <= dec_cnt_reg + 1'b1;
      // Malformed words are counted whenever the engine is not frozen.
      if (!halt_reg && is_bad && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= res_data;
      type_mem[wr_ptr_reg] <= res_type;
      seq_mem[wr_ptr_reg]  <= seq_reg;
    end
  end

  always_comb begin
    m_valid   = (occ_reg != '0);
    m_data    = m_valid ? data_mem[rd_ptr_reg] : '0;
    m_type    = m_valid ? type_mem[rd_ptr_reg] : T_INVALID;
    m_seq     = m_valid ? seq_mem[rd_ptr_reg]  : '0;
    halt      = halt_reg;
    occupancy = occ_reg;
    enc_cnt   = enc_cnt_reg;
    dec_cnt   = dec_cnt_reg;
    err_cnt   = err_cnt_reg;
  end

endmodule

// File: tb/tb_aes_result_collector.sv
// Bench for aes_result_collector: directed vector table, hand-written corner
// sequences and a random run, all checked against a queue-based model.
module tb_aes_result_collector;

  localparam int DEPTH = 8;
  localparam int THR   = DEPTH;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [1:0] I = 2'b00, E = 2'b01, D = 2'b10, M = 2'b11;
  localparam logic [127:0] W1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] W2 = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] res_data = '0;
  logic [1:0] res_type = I;
  logic halt, flush = 1'b0, m_valid, m_ready = 1'b0;
  logic [127:0] m_data;
  logic [1:0] m_type;
  logic [7:0] m_seq;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] enc_cnt, dec_cnt, err_cnt;

  aes_result_collector #(.DEPTH(DEPTH), .HALT_THRESH(THR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .res_data(res_data), .res_type(res_type), .halt(halt),
    .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_type(m_type), .m_seq(m_seq), .occupancy(occupancy), .enc_cnt(enc_cnt),
    .dec_cnt(dec_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of tagged results plus counters.
  typedef struct { logic [127:0] d; logic [1:0] t; logic [7:0] s; } ent_t;
  ent_t q[$];
  logic [7:0] pop_seq_log[$];
  logic [127:0] pop_data_log[$];
  int seq_m, enc_m, dec_m, err_m;
  bit halt_m, last_push;
  int n_err = 0, n_chk = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); pop_seq_log.delete(); pop_data_log.delete();
    seq_m = 0; enc_m = 0; dec_m = 0; err_m = 0; halt_m = 0; last_push = 0;
  endtask

  task automatic check_model();
    bit v;
    v = (q.size() != 0);
    chk("m_valid", m_valid, v);
    chk("m_data", m_data, v ? q[0].d : '0);
    chk("m_type", m_type, v ? q[0].t : I);
    chk("m_seq", m_seq, v ? q[0].s : 8'd0);
    chk("occupancy", occupancy, q.size());
    chk("halt", halt, halt_m);
    chk("enc_cnt", enc_cnt, enc_m);
    chk("dec_cnt", dec_cnt, dec_m);
    chk("err_cnt", err_cnt, err_m);
  endtask

  task automatic model_update(input logic [127:0] d, input logic [1:0] t, input bit r, input bit f);
    bit push, pop;
    ent_t e;
    push = !halt_m && !f && (t == E || t == D);
    pop  = (q.size() != 0) && r && !f;
    if (!halt_m && t == M && err_m < CMAX) err_m++;
    if (f) begin
      q.delete();
      seq_m = 0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        pop_seq_log.push_back(e.s);
        pop_data_log.push_back(e.d);
        $display("pop seq=%0d type=%0d data=%h", e.s, e.t, e.d);
      end
      if (push) begin
        q.push_back('{d: d, t: t, s: 8'(seq_m)});
        seq_m = (seq_m + 1) % 256;
        if (t == E && enc_m < CMAX) enc_m++;
        if (t == D && dec_m < CMAX) dec_m++;
      end
    end
    last_push = push;
    halt_m = !f && (q.size() >= THR);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic [127:0] d, input logic [1:0] t, input bit r, input bit f);
    res_data = d; res_type = t; m_ready = r; flush = f;
    @(negedge clk);
    check_model();
    model_update(d, t, r, f);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; res_type = I; m_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] t; logic [127:0] d; bit r;
    bit ev; logic [127:0] ed; logic [1:0] et; logic [7:0] es; int eocc; int eenc; int edec; int eerr;
  } vec_t;
  vec_t vt[11];

  initial begin
    int k, guard;
    logic [127:0] cd;
    logic [1:0] ct;
    bit rdy;

    vt[0]  = '{E, W1, 1, 1, W1, E, 0, 1, 1, 0, 0};
    vt[1]  = '{I, 0,  1, 0, 0,  I, 0, 0, 1, 0, 0};
    vt[2]  = '{E, W1, 0, 1, W1, E, 1, 1, 2, 0, 0};
    vt[3]  = '{D, W2, 0, 1, W1, E, 1, 2, 2, 1, 0};
    vt[4]  = '{I, 0,  1, 1, W2, D, 2, 1, 2, 1, 0};
    vt[5]  = '{I, 0,  1, 0, 0,  I, 0, 0, 2, 1, 0};
    vt[6]  = '{M, W1, 0, 0, 0,  I, 0, 0, 2, 1, 1};
    vt[7]  = '{M, W2, 0, 0, 0,  I, 0, 0, 2, 1, 2};
    vt[8]  = '{M, W1, 0, 0, 0,  I, 0, 0, 2, 1, 3};
    vt[9]  = '{I, W1, 0, 0, 0,  I, 0, 0, 2, 1, 3};
    vt[10] = '{I, W2, 0, 0, 0,  I, 0, 0, 2, 1, 3};

    apply_reset();
    chk("rst_type", m_type, I);
    for (int i = 0; i < 11; i++) begin
      step(vt[i].d, vt[i].t, vt[i].r, 1'b0);
      chk($sformatf("vec%0d_valid", i), m_valid, vt[i].ev);
      chk($sformatf("vec%0d_data", i), m_data, vt[i].ed);
      chk($sformatf("vec%0d_type", i), m_type, vt[i].et);
      chk($sformatf("vec%0d_seq", i), m_seq, vt[i].es);
      chk($sformatf("vec%0d_occ", i), occupancy, vt[i].eocc);
      chk($sformatf("vec%0d_cnt", i), {enc_cnt, dec_cnt, err_cnt},
          {16'(vt[i].eenc), 16'(vt[i].edec), 16'(vt[i].eerr)});
    end

    // Back-pressure: ten results, downstream stalled, the engine holds while halted.
    apply_reset();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      step(128'(k), E, 1'b0, 1'b0);
      if (last_push) k++;
    end
    chk("bp_full_halt", halt, 1'b1);
    chk("bp_full_occ", occupancy, 8);
    step(128'(k), E, 1'b1, 1'b0);
    chk("bp_release_halt", halt, 1'b0);
    chk("bp_release_occ", occupancy, 7);
    step(128'(k), E, 1'b0, 1'b0);
    if (last_push) k++;
    chk("bp_refill_occ", occupancy, 8);
    chk("bp_refill_halt", halt, 1'b1);
    guard = 0;
    while ((k < 10 || q.size() != 0) && guard < 40) begin
      step(128'(k), (k < 10) ? E : I, 1'b1, 1'b0);
      if (last_push) k++;
      guard++;
    end
    chk("bp_drain_in_time", guard < 40, 1'b1);
    chk("bp_pop_count", pop_seq_log.size(), 10);
    for (int i = 0; i < 10 && i < pop_seq_log.size(); i++) begin
      chk($sformatf("bp_seq%0d", i), pop_seq_log[i], 8'(i));
      chk($sformatf("bp_data%0d", i), pop_data_log[i], 128'(i));
    end

    // Sequence wrap across 257 results.
    apply_reset();
    for (int i = 0; i < 257; i++) step(128'(i) ^ W1, E, 1'b1, 1'b0);
    step(0, I, 1'b1, 1'b0);
    step(0, I, 1'b1, 1'b0);
    chk("wrap_enc_cnt", enc_cnt, 257);
    chk("wrap_pops", pop_seq_log.size(), 257);
    if (pop_seq_log.size() == 257) begin
      chk("wrap_seq255", pop_seq_log[255], 8'd255);
      chk("wrap_seq256", pop_seq_log[256], 8'd0);
    end

    // Flush beats a simultaneous push; counters survive.
    apply_reset();
    for (int i = 0; i < 5; i++) step(W2 + 128'(i), D, 1'b0, 1'b0);
    chk("fl_pre_occ", occupancy, 5);
    chk("fl_pre_halt", halt, 1'b0);
    step(W1, E, 1'b1, 1'b1);
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", m_valid, 1'b0);
    chk("fl_dec_kept", dec_cnt, 5);
    chk("fl_enc", enc_cnt, 0);
    step(W1, E, 1'b0, 1'b0);
    chk("fl_seq_restart", m_seq, 8'd0);
    chk("fl_valid_after", m_valid, 1'b1);

    // Asynchronous reset drops halt without a clock edge.
    apply_reset();
    for (int i = 0; i < 8; i++) step(128'(i), E, 1'b0, 1'b0);
    chk("ar_halt_before", halt, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_halt_async", halt, 1'b0);
    chk("ar_occ_async", occupancy, 0);
    chk("ar_valid_async", m_valid, 1'b0);
    chk("ar_enc_async", enc_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Random traffic; the engine freezes its output whenever halt is high.
    cd = '0; ct = I;
    for (int c = 0; c < 3000; c++) begin
      if (!halt_m) begin
        k = $urandom_range(0, 9);
        ct = (k < 4) ? E : (k < 7) ? D : (k < 9) ? I : M;
        cd = {$urandom, $urandom, $urandom, $urandom};
      end
      rdy = ($urandom_range(0, 99) < (((c / 300) % 2) != 0 ? 20 : 75));
      step(cd, ct, rdy, $urandom_range(0, 99) == 0);
    end
    step(0, I, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
